// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of the cpu_ram valid/ready port.
// One transaction per grant, fields latched at grant, watchdog on slave acknowledge.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned TIMEOUT  = 63,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,

  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,

  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,

  output logic              timeout_err,
  output logic              grant_id
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        wd_q, wd_d;
  logic              last_q, last_d;
  logic              gid_q, gid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        ready_q, ready_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              terr_q, terr_d;
  logic              sel;
  logic [31:0]       resp;

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    last_d   = last_q;
    gid_d    = gid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    ready_d  = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    terr_d   = 1'b0;
    sel      = 1'b0;
    resp     = s_rdata;

    unique case (state_q)
      StIdle: begin
        if (m0_valid || m1_valid) begin
          // On contention the master that was not served last wins.
          sel     = (m0_valid && m1_valid) ? ~last_q : m1_valid;
          gid_d   = sel;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          wstrb_d = sel ? m1_wstrb : m0_wstrb;
          wd_d    = 8'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (s_ready || wd_q == WdLast) begin
          // A late s_ready on the final watchdog cycle still counts as success.
          resp    = s_ready ? s_rdata : ERR_DATA;
          terr_d  = ~s_ready;
          if (gid_q) begin
            rdata1_d   = resp;
            ready_d[1] = 1'b1;
          end else begin
            rdata0_d   = resp;
            ready_d[0] = 1'b1;
          end
          last_d  = gid_q;
          state_d = StDone;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      wd_q     <= 8'd0;
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      ready_q  <= 2'b00;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      ready_q  <= ready_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      terr_q   <= terr_d;
    end
  end

  assign s_valid     = (state_q == StBusy);
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_wstrb     = wstrb_q;
  assign m0_ready    = ready_q[0];
  assign m1_ready    = ready_q[1];
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign timeout_err = terr_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural transaction model checked every cycle,
// a simple RAM slave with programmable latency, and directed master scenarios.
module tb_ram_arbiter;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned TIMEOUT  = 63;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              m0_valid, m1_valid, m0_ready, m1_ready;
  logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
  logic [31:0]       m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]        m0_wstrb, m1_wstrb, s_wstrb;
  logic              s_valid, s_ready, timeout_err, grant_id;

  ram_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_err(timeout_err), .grant_id(grant_id)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: owner of the in-flight transaction (-1 = none) and
  // how many slave cycles it has been waiting.
  int                owner = -1;
  int                waited = 0;
  int                last = 1;
  bit                cool = 1'b0;
  bit                model_ok = 1'b0;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata, e_rdata0, e_rdata1;
  logic [3:0]        e_wstrb;
  logic              e_ready0, e_ready1, e_terr, e_gid;

  always @(posedge clk) begin
    if (!reset) begin
      owner = -1; waited = 0; last = 1; cool = 1'b0; model_ok = 1'b1;
      e_addr = '0; e_wdata = 0; e_wstrb = 0; e_rdata0 = 0; e_rdata1 = 0;
      e_ready0 = 0; e_ready1 = 0; e_terr = 0; e_gid = 0;
    end else if (cool) begin
      cool = 1'b0; e_ready0 = 0; e_ready1 = 0; e_terr = 0;
    end else if (owner < 0) begin
      if (m0_valid || m1_valid) begin
        if (m0_valid && m1_valid) owner = 1 - last;
        else owner = m1_valid ? 1 : 0;
        e_addr  = (owner == 1) ? m1_addr  : m0_addr;
        e_wdata = (owner == 1) ? m1_wdata : m0_wdata;
        e_wstrb = (owner == 1) ? m1_wstrb : m0_wstrb;
        e_gid   = (owner == 1);
        waited  = 0;
      end
    end else begin
      waited++;
      if (s_ready || waited == int'(TIMEOUT)) begin
        e_terr = !s_ready;
        if (owner == 1) begin
          e_rdata1 = s_ready ? s_rdata : ERR_DATA; e_ready1 = 1;
        end else begin
          e_rdata0 = s_ready ? s_rdata : ERR_DATA; e_ready0 = 1;
        end
        last = owner; owner = -1; cool = 1'b1;
      end
    end
  end

  int   gq[$];
  int   rc0 = 0, rc1 = 0;
  logic prev_sv = 1'b0;

  always @(negedge clk) begin
    if (model_ok) begin
      check("s_valid", 32'(s_valid), 32'(owner >= 0));
      check("s_addr", 32'(s_addr), 32'(e_addr));
      check("s_wdata", s_wdata, e_wdata);
      check("s_wstrb", 32'(s_wstrb), 32'(e_wstrb));
      check("m0_ready", 32'(m0_ready), 32'(e_ready0));
      check("m1_ready", 32'(m1_ready), 32'(e_ready1));
      check("m0_rdata", m0_rdata, e_rdata0);
      check("m1_rdata", m1_rdata, e_rdata1);
      check("timeout_err", 32'(timeout_err), 32'(e_terr));
      check("grant_id", 32'(grant_id), 32'(e_gid));
      if (s_valid === 1'b1 && prev_sv !== 1'b1) gq.push_back(int'(grant_id));
      if (m0_ready === 1'b1) rc0++;
      if (m1_ready === 1'b1) rc1++;
      prev_sv = s_valid;
    end
  end

  // RAM slave: acknowledges after slave_lat extra cycles; negative = never.
  logic [31:0] mem [256];
  int          slave_lat = 0;

  initial begin : slave
    int s_cnt;
    int idx;
    s_cnt = 0;
    s_ready = 1'b0;
    s_rdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      if (s_valid === 1'b1 && slave_lat >= 0) begin
        if (s_cnt >= slave_lat) begin
          idx = int'(s_addr[9:2]);
          s_rdata = mem[idx];
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[idx][8*b +: 8] = s_wdata[8*b +: 8];
          s_ready = 1'b1;
          s_cnt = 0;
        end else begin
          s_cnt++;
        end
      end else begin
        s_cnt = 0;
      end
    end
  end

  task automatic do_txn(input int m, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [ADDR_W-1:0] alt_addr,
                        output logic [31:0] rdata);
    int n = 0;
    bit seen = 1'b0;
    rdata = 32'd0;
    if (m == 1) begin
      m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
    end else begin
      m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
    end
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if ((m == 1) ? m1_ready : m0_ready) begin
        seen = 1'b1;
        rdata = (m == 1) ? m1_rdata : m0_rdata;
      end else if (n == 3 && alt_addr != '0) begin
        if (m == 1) m1_addr = alt_addr;
        else m0_addr = alt_addr;
      end
    end
    check($sformatf("ready_wait_m%0d", m), 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    if (m == 1) m1_valid = 1'b0;
    else m0_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] r0 [4];
    logic [31:0] r1 [4];
    int n, busy;
    bit seen;
    reset = 1'b0;
    m0_valid = 0; m0_addr = '0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = '0; m1_wdata = 0; m1_wstrb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Both masters contend from reset: grants alternate starting with m0.
    gq.delete(); rc0 = 0; rc1 = 0;
    fork
      for (int i = 0; i < 4; i++)
        do_txn(0, 15'(32'h100 + 4 * (i % 2)), 32'hA0A0_0000 + i, (i < 2) ? 4'hF : 4'h0,
               '0, r0[i]);
      for (int j = 0; j < 4; j++)
        do_txn(1, 15'(32'h200 + 4 * (j % 2)), 32'hB1B1_0000 + j, (j < 2) ? 4'hF : 4'h0,
               '0, r1[j]);
    join
    check("rr_grants", 32'(gq.size()), 32'd8);
    for (int k = 0; k < gq.size() && k < 8; k++) check("rr_order", 32'(gq[k]), 32'(k % 2));
    check("rr_m0_pulses", 32'(rc0), 32'd4);
    check("rr_m1_pulses", 32'(rc1), 32'd4);
    check("rr_m0_rd0", r0[2], 32'hA0A0_0000);
    check("rr_m0_rd1", r0[3], 32'hA0A0_0001);
    check("rr_m1_rd0", r1[2], 32'hB1B1_0000);
    check("rr_m1_rd1", r1[3], 32'hB1B1_0001);

    // Single master write then read.
    rc1 = 0;
    do_txn(0, 15'h0010, 32'h1234_5678, 4'hF, '0, rd);
    do_txn(0, 15'h0010, 32'h0, 4'h0, '0, rd);
    check("single_rdata", rd, 32'h1234_5678);
    check("single_m1_idle", 32'(rc1), 32'd0);

    // Master field changes during BUSY must not reach the slave port.
    slave_lat = 6;
    fork
      do_txn(1, 15'h0020, 32'hCAFE_0001, 4'hF, 15'h0040, rd);
      begin
        repeat (5) @(negedge clk);
        check("latch_s_addr", 32'(s_addr), 32'h0020);
      end
    join
    slave_lat = 0;
    do_txn(1, 15'h0020, 32'h0, 4'h0, '0, rd);
    check("latch_rd20", rd, 32'hCAFE_0001);
    do_txn(1, 15'h0040, 32'h0, 4'h0, '0, rd);
    check("latch_rd40", rd, 32'h0);

    // Partial-strobe writes merge in the slave word.
    do_txn(1, 15'h0030, 32'hAAAA_AAAA, 4'b0011, '0, rd);
    do_txn(1, 15'h0030, 32'h5555_5555, 4'b1100, '0, rd);
    do_txn(1, 15'h0030, 32'h0, 4'h0, '0, rd);
    check("merge_rdata", rd, 32'h5555_AAAA);

    // Watchdog: slave never answers.
    slave_lat = -1;
    m0_addr = 15'h0010; m0_wdata = 0; m0_wstrb = 4'h0; m0_valid = 1'b1;
    n = 0; busy = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (m0_ready) seen = 1'b1;
      else if (s_valid) busy++;
    end
    check("to_seen", 32'(seen), 32'd1);
    check("to_busy_cycles", 32'(busy), 32'(TIMEOUT));
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("to_s_valid", 32'(s_valid), 32'd0);
    @(posedge clk);
    #1 m0_valid = 1'b0;
    slave_lat = 1;
    do_txn(1, 15'h0010, 32'h0, 4'h0, '0, rd);
    check("after_to_rdata", rd, 32'h1234_5678);

    // Reset while an m1 read is pending.
    slave_lat = -1;
    m1_addr = 15'h0010; m1_wstrb = 4'h0; m1_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_s_valid", 32'(s_valid), 32'd1);
    rc1 = 0;
    @(posedge clk);
    #1 reset = 1'b0; m1_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_s_valid", 32'(s_valid), 32'd0);
    check("mid_rst_m0_rdata", m0_rdata, 32'd0);
    check("mid_rst_m1_rdata", m1_rdata, 32'd0);
    check("mid_rst_s_addr", 32'(s_addr), 32'd0);
    slave_lat = 0;
    gq.delete();
    fork
      do_txn(0, 15'h0010, 32'h0, 4'h0, '0, r0[0]);
      do_txn(1, 15'h0030, 32'h0, 4'h0, '0, r1[0]);
    join
    check("rst_no_m1_pulse_then_one", 32'(rc1), 32'd1);
    check("rst_first_grant", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);
    check("rst_m0_rdata", r0[0], 32'h1234_5678);
    check("rst_m1_rdata", r1[0], 32'h5555_AAAA);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-master, one-slave arbiter that shares the cpu_ram valid/ready memory port between two requesters. Port 0 is the CPU; port 1 is a DMA or debug master. Each grant carries exactly one transaction. Arbitration is round-robin, request fields are latched at grant, and a watchdog terminates transactions the slave never acknowledges. The block sits between the masters and cpu_ram. Its slave port connects directly to cpu_ram's addr/wdata/wstrb/valid/ready/rdata.

Parameters:
ADDR_W, 15, byte-address width on all ports (cpu_ram SIZE 13 + 2)
TIMEOUT, 63, maximum BUSY cycles to wait for s_ready; range 1..255
ERR_DATA, 32'hDEADBEEF, rdata returned on a timed-out read

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low; 0 = in reset
m0_valid  in  1  master 0 request; held high until m0_ready
m0_addr  in  ADDR_W  master 0 byte address
m0_wdata  in  32  master 0 write data
m0_wstrb  in  4  master 0 byte strobes; 0000 = read
m0_ready  out  1  one-cycle completion pulse to master 0
m0_rdata  out  32  read data; valid when m0_ready=1
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same as m0_*, for master 1
s_valid  out  1  request to cpu_ram
s_addr  out  ADDR_W  latched address
s_wdata  out  32  latched write data
s_wstrb  out  4  latched strobes
s_ready  in  1  cpu_ram completion
s_rdata  in  32  cpu_ram read data
timeout_err  out  1  one-cycle pulse when a transaction is terminated by the watchdog
grant_id  out  1  master owning the current or last transaction

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, including rdata registers and grant_id.
  - Round-robin pointer selects m0 first.
  - Reset mid-transaction aborts it: no ready pulse is issued, and s_valid is 0 from the next cycle.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If exactly one valid is high, grant that master.
  - If both are high, grant the master that is not the last served (m0 after reset).
  - On grant: latch addr/wdata/wstrb into s_* registers, set grant_id, clear the watchdog counter, go to BUSY.
- BUSY:
  - s_valid=1 and the s_* fields stay constant.
  - Master-side field changes after grant are ignored.
  - On s_ready=1: register s_rdata into the granted mX_rdata, pulse mX_ready for the next cycle, drop s_valid, update the round-robin pointer, go to DONE.
  - Watchdog counter increments every BUSY cycle without s_ready.
  - When the counter reaches TIMEOUT without s_ready: drop s_valid, pulse mX_ready with mX_rdata=ERR_DATA (also for writes), pulse timeout_err, go to DONE.
  - s_ready in the same cycle the counter reaches TIMEOUT: treated as normal completion; no error.
- DONE:
  - mX_ready=1 for this single cycle.
  - No new grant is made this cycle, so a master's stale valid is never re-granted.
  - Go to IDLE.
- Latency:
  - Valid sampled at edge N (IDLE) gives s_valid high from cycle N+1.
  - s_ready sampled at edge K gives mX_ready high during cycle K+1.
  - Minimum turnaround is 3 cycles per transaction. The next grant is decided in the cycle after DONE.
- Per-master rdata holds its last value between transactions. The non-granted master's ready stays 0.
- s_ready outside BUSY is ignored.
- Only one transaction is outstanding at any time. No pipelining.

Test Plan:
- Single master: m0 writes 0x12345678, wstrb=1111, addr 0x0010, then reads addr 0x0010 → s_valid one cycle after request. m0_ready pulses once per transaction. m0_rdata=0x12345678. m1_ready stays 0.
- Simultaneous requests after reset: m0 and m1 both request for 4 transactions each → grants alternate m0, m1, m0, m1…; each master sees exactly 4 ready pulses; data integrity holds per master.
- Field latching: m1 changes m1_addr from 0x0020 to 0x0040 during BUSY → s_addr stays 0x0020 until completion.
- Byte/halfword pass-through: m1 writes wstrb=0011, then 1100, then reads → s_wstrb matches the latched strobes; the read returns the merged word.
- Watchdog: s_ready tied 0, m0 reads → after TIMEOUT(63) BUSY cycles, timeout_err and m0_ready pulse together, m0_rdata=0xDEADBEEF, s_valid=0. A following m1 request is served normally.
- Reset mid-BUSY: assert reset=0 for one cycle during a pending m1 read → no m1_ready pulse, all outputs 0, next simultaneous request grants m0.
